// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, bubble encoding, and the register-field
// usage rules that the fetch, decode and hazard logic all agree on.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    OP_IMM = 7'b0010011,
    AUIPC  = 7'b0010111,
    STORE  = 7'b0100011,
    OP     = 7'b0110011,
    LUI    = 7'b0110111,
    BRANCH = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111
  } opcode_e;

  typedef logic [4:0] reg_idx_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_rsp_t;

  function automatic logic uses_rd(input logic [6:0] opc);
    return !(opc == STORE || opc == BRANCH);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == LUI || opc == AUIPC || opc == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP || opc == STORE || opc == BRANCH);
  endfunction

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Fetch/IF-ID boundary bundle: stall and redirect controls in, instruction
// memory port, and the IF/ID register plus pre-decoded fields out.
interface fetch_ifid_stage_if;
  import rv32_pkg::*;

  logic            ena_fetch;
  logic            ena_ifid;
  logic            jmp_ena;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr_ID;
  logic [XLEN-1:0] pc_ID;
  logic            valid_ID;
  reg_idx_t        rs1_ID;
  reg_idx_t        rs2_ID;
  reg_idx_t        rd_ID;
  logic            misalign;

  modport master (
    input  ena_fetch, ena_ifid, jmp_ena, jmp_pc, imem_rdata,
    output imem_addr, instr_ID, pc_ID, valid_ID, rs1_ID, rs2_ID, rd_ID, misalign
  );

  modport slave (
    output ena_fetch, ena_ifid, jmp_ena, jmp_pc, imem_rdata,
    input  imem_addr, instr_ID, pc_ID, valid_ID, rs1_ID, rs2_ID, rd_ID, misalign
  );

endinterface

// File: rtl/ifid_field_decode.sv
// Combinational register-field extraction from the IF/ID instruction; fields an
// opcode does not use, and every field of an invalid slot, read as x0.
module ifid_field_decode
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic            valid,
  output reg_idx_t        rs1,
  output reg_idx_t        rs2,
  output reg_idx_t        rd
);

  logic [6:0] opc;

  always_comb begin
    opc = instr[6:0];
    rs1 = '0;
    rs2 = '0;
    rd  = '0;
    if (valid) begin
      if (uses_rs1(opc)) rs1 = instr[19:15];
      if (uses_rs2(opc)) rs2 = instr[24:20];
      if (uses_rd(opc))  rd  = instr[11:7];
    end
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// PC/fetch stage and IF/ID register; imem responses arrive one cycle after issue.
// Stalls park at most one in-flight response in a hold buffer; redirects cost two bubbles.
module fetch_ifid_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = RV32_NOP
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ifid_stage_if.master bus
);

  logic [XLEN-1:0] pc_f;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic            hold_valid;
  fetch_rsp_t      hold_q;
  fetch_rsp_t      ifid_q;
  logic            valid_q;
  logic            misalign_q;

  logic            redirect;
  logic            src_valid;
  fetch_rsp_t      src;
  fetch_rsp_t      mem_rsp;
  logic            hold_valid_next;
  logic            issue;
  logic [XLEN-1:0] jmp_target;
  logic [XLEN-1:0] pc_plus4;

  always_comb begin
    redirect   = bus.jmp_ena & bus.ena_ifid;
    jmp_target = {bus.jmp_pc[XLEN-1:2], 2'b00};
    pc_plus4   = pc_f + 32'd4;

    mem_rsp.instr = bus.imem_rdata;
    mem_rsp.pc    = req_pc;

    // The hold buffer is older than any in-flight read, so it drains first.
    src_valid = hold_valid | req_valid;
    src       = hold_valid ? hold_q : mem_rsp;

    hold_valid_next = bus.ena_ifid ? 1'b0 : (hold_valid | req_valid);

    // A new read may only go out if its response will have somewhere to land.
    issue = bus.ena_fetch & ~redirect & ~hold_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f         <= RESET_PC;
      req_valid    <= 1'b0;
      req_pc       <= '0;
      hold_valid   <= 1'b0;
      hold_q       <= '0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= '0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= redirect & (|bus.jmp_pc[1:0]);

      if (redirect) begin
        pc_f         <= jmp_target;
        req_valid    <= 1'b0;
        hold_valid   <= 1'b0;
        ifid_q.instr <= NOP_INSTR;
        valid_q      <= 1'b0;
      end else begin
        if (bus.ena_ifid) begin
          hold_valid <= 1'b0;
          valid_q    <= src_valid;
          if (src_valid) begin
            ifid_q <= src;
          end else begin
            ifid_q.instr <= NOP_INSTR;
          end
        end else if (req_valid && !hold_valid) begin
          hold_valid <= 1'b1;
          hold_q     <= mem_rsp;
        end

        if (issue) begin
          req_valid <= 1'b1;
          req_pc    <= pc_f;
          pc_f      <= pc_plus4;
        end else begin
          req_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_addr = pc_f;
  assign bus.instr_ID  = ifid_q.instr;
  assign bus.pc_ID     = ifid_q.pc;
  assign bus.valid_ID  = valid_q;
  assign bus.misalign  = misalign_q;

  ifid_field_decode u_decode (
    .instr (ifid_q.instr),
    .valid (valid_q),
    .rs1   (bus.rs1_ID),
    .rs2   (bus.rs2_ID),
    .rd    (bus.rd_ID)
  );

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core, directly upstream of the stall/hazard controller. Owns the PC, issues addresses to the synchronous instruction memory (1-cycle read latency) and absorbs stalls from ena_fetch/ena_ifid with a one-entry hold buffer. Applies jump redirects from ID. Presents instr/PC to ID, plus pre-decoded rs1_ID/rs2_ID/rd_ID (zeroed when unused) to the hazard controller.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
ena_fetch  in  1  from stall control; 1 = PC may advance
ena_ifid  in  1  from stall control; 1 = IF/ID may load
jmp_ena  in  1  from ID; redirect request, honoured only when ena_ifid=1
jmp_pc  in  32  redirect target
imem_addr  out  32  instruction-memory address (= pc_F register)
imem_rdata  in  32  data for the address presented the previous cycle
instr_ID  out  32  IF/ID instruction
pc_ID  out  32  IF/ID PC
valid_ID  out  1  IF/ID holds a real instruction
rs1_ID  out  5  source 1 field, 0 if unused or invalid
rs2_ID  out  5  source 2 field, 0 if unused or invalid
rd_ID  out  5  destination field, 0 if unused or invalid
misalign  out  1  1-cycle pulse: accepted jmp_pc had bits[1:0]!=0

Behaviour:
- Every register updates on posedge clk only.
- Reset (rst=1, dominates all inputs): pc_F=RESET_PC, req_valid=0, hold_valid=0, valid_ID=0, instr_ID=NOP_INSTR, pc_ID=0, misalign=0. rst asserted mid-stall or mid-redirect discards the in-flight response and the hold buffer.
- Internal state: req_valid/req_pc (response due this cycle), hold_valid/hold_instr/hold_pc.
- Response source: hold buffer if hold_valid, else imem_rdata/req_pc if req_valid, else none.
- Redirect (jmp_ena=1 and ena_ifid=1, highest priority after rst): pc_F<=jmp_pc with bits[1:0] forced to 00; req_valid<=0; hold_valid<=0; IF/ID loads a bubble; misalign<=|jmp_pc[1:0]. Next cycle imem_addr=target; target instruction reaches IF/ID 2 cycles after the redirect edge (2-bubble penalty).
- jmp_ena while ena_ifid=0: ignored. ID re-asserts it once the stall clears.
- Normal load (ena_ifid=1, no redirect): IF/ID loads the response source (valid_ID=1) or, if none, a bubble (valid_ID=0, instr_ID=NOP_INSTR, pc_ID held). hold_valid<=0.
- Stall (ena_ifid=0): IF/ID holds. If req_valid and !hold_valid, capture the response into the hold buffer.
- PC advance: issue allowed when ena_fetch=1 and the slot is free. Free = hold buffer empty after this edge, or the buffer is consumed this edge. On issue: req_pc<=pc_F, req_valid<=1, pc_F<=pc_F+4 (32-bit wrap from 0xFFFF_FFFC to 0). Otherwise req_valid<=0 and pc_F holds. Never more than one unconsumed response, so none is lost.
- Field decode from IF/ID (combinational): opcode=instr_ID[6:0].
  - rd_ID=instr[11:7], except 0 for STORE, BRANCH, or !valid_ID.
  - rs1_ID=instr[19:15], except 0 for LUI, AUIPC, JAL, or !valid_ID.
  - rs2_ID=instr[24:20] only for OP, STORE, BRANCH; else 0.

Decomposition:
- Shared package rv32_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), NOP_INSTR value, XLEN=32. The hazard controller and decoder reuse these.
- One combinational sub-module, ifid_field_decode (instr, valid -> rs1/rs2/rd). The hold buffer and PC logic stay inline.

Test Plan:
- Reset, then free-run with ROM[i]=i: imem_addr=0,4,8…; first valid_ID=1 two cycles after rst falls, with pc_ID=0; then one instruction per cycle.
- Stall 3 cycles (ena_fetch=ena_ifid=0) mid-stream with the response for 0x10 in flight: IF/ID holds 0x0C; on release 0x10 then 0x14 appear with no loss or duplication.
- jmp_ena=1, jmp_pc=0x100 while IF/ID holds 0x08: next two IF/ID cycles are bubbles (valid_ID=0, instr=0x13), then pc_ID=0x100.
- jmp_ena=1 with ena_ifid=0: no redirect. Reassert with ena_ifid=1, jmp_pc=0x102: redirect to 0x100, misalign pulses for exactly 1 cycle.
- Field decode: instr 0x00B50533 (add) -> rs1=10, rs2=11, rd=10. sw 0x00A12023 -> rd=0, rs1=2, rs2=10. lui -> rs1=0, rs2=0. Bubble -> all 0.
- rst asserted during a stall with hold_valid=1: next cycle valid_ID=0, imem_addr=RESET_PC, hold discarded.
